// File: rtl/scan_mux_pkg.sv
// scan_mux_pkg: shared types and helpers for the scanning N-to-1 selector.
// Latency: n/a (types, constants and a pure combinational helper only).
// Backpressure: n/a.
package scan_mux_pkg;

    // Controller states: parked, following sel, or stepping through channels.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_e;

    // Value of the mode input, sampled on start.
    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Dwell counter is wide enough for the largest dwell of 65535 cycles.
    localparam int CNT_W = 16;

    // Increment-with-wrap over n channels; the unmasked scan uses this directly.
    function automatic int unsigned next_index(input int unsigned cur, input int unsigned n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/scan_mux_next_chan.sv
// scan_mux_next_chan: wrap-around priority search for the next enabled channel above cur_sel.
// Latency: purely combinational.
// Backpressure: none; found_o=0 when no channel is enabled so the caller can hold.
module scan_mux_next_chan
    import scan_mux_pkg::*;
#(
    parameter int  CHANNELS = 16,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [SEL_W-1:0]    cur_sel_i,
    input  logic [CHANNELS-1:0] mask_i,
    output logic [SEL_W-1:0]    next_sel_o,
    output logic                found_o
);

    // One extra bit so cur_sel + offset never overflows before the modulo step.
    logic [SEL_W:0] cand;

    // Walk offsets from farthest to nearest so the nearest enabled channel wins
    // by being written last; offset CHANNELS lands back on cur_sel itself.
    always_comb begin
        next_sel_o = '0;
        found_o    = 1'b0;
        cand       = '0;
        for (int off = CHANNELS; off >= 1; off--) begin
            cand = {1'b0, cur_sel_i} + (SEL_W+1)'(off);
            if (cand >= (SEL_W+1)'(CHANNELS)) begin
                cand = cand - (SEL_W+1)'(CHANNELS);
            end
            if (mask_i[cand[SEL_W-1:0]]) begin
                next_sel_o = cand[SEL_W-1:0];
                found_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/scan_mux_n_to_1.sv
// scan_mux_n_to_1: registered N-to-1 selector with manual select and timed auto-scan.
// Latency: sel->cur_sel 1 cycle, cur_sel->y 1 cycle; start->first valid y 2 cycles.
// Backpressure: none; en gates y/y_valid to 0 on the next cycle. Macro SCAN_MUX_CH_MASK_EN adds a channel mask.
module scan_mux_n_to_1
    import scan_mux_pkg::*;
#(
    parameter int  WIDTH    = 1,
    parameter int  CHANNELS = 16,
    parameter int  DWELL    = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] d,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      en,
`ifdef SCAN_MUX_CH_MASK_EN
    input  logic [CHANNELS-1:0]       mask,
`endif
    output logic [WIDTH-1:0]          y,
    output logic                      y_valid,
    output logic [SEL_W-1:0]          cur_sel,
    output logic                      wrap
);

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DWELL - 1);

    state_e           state_q,   state_d;
    logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             wrap_q,    wrap_d;
    logic [WIDTH-1:0] y_q,       y_d;
    logic             y_valid_q, y_valid_d;

    logic [WIDTH-1:0]    chan [CHANNELS];
    logic [CHANNELS-1:0] chan_en;
    logic [SEL_W-1:0]    adv_sel;
    logic                adv_found;
    logic                adv_wrap;
    logic                sel_ok;
    logic                live;

    // Unpack the flat input bus into one entry per channel.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        assign chan[k] = d[k*WIDTH +: WIDTH];
    end

`ifdef SCAN_MUX_CH_MASK_EN
    assign chan_en = mask;

    scan_mux_next_chan #(
        .CHANNELS (CHANNELS)
    ) u_next_chan (
        .cur_sel_i  (cur_sel_q),
        .mask_i     (mask),
        .next_sel_o (adv_sel),
        .found_o    (adv_found)
    );

    // Any step that does not move strictly upward has passed through (or onto) channel 0.
    assign adv_wrap = adv_found && (adv_sel <= cur_sel_q);
`else
    assign chan_en   = '1;
    assign adv_sel   = SEL_W'(next_index(32'(cur_sel_q), 32'(CHANNELS)));
    assign adv_found = 1'b1;
    assign adv_wrap  = (adv_sel == '0);
`endif

    // Out-of-range manual selects are dropped rather than aliased onto a real channel.
    assign sel_ok = (32'(sel) < 32'(CHANNELS));

    // A pending stop already counts as idle so y_valid falls on the same edge the state does.
    assign live = (state_q != IDLE) && !stop && en && chan_en[cur_sel_q];

    // Next-state: mode/state transitions, manual tracking, dwell counting and channel advance.
    always_comb begin
        state_d   = state_q;
        cur_sel_d = cur_sel_q;
        cnt_d     = cnt_q;
        wrap_d    = 1'b0;
        if (stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (mode == MODE_SCAN) begin
                            state_d   = SCAN;
                            cur_sel_d = '0;
                            cnt_d     = CNT_RELOAD;
                        end else begin
                            state_d = MANUAL;
                            if (sel_ok) begin
                                cur_sel_d = sel;
                            end
                        end
                    end
                end
                MANUAL: begin
                    if (sel_ok) begin
                        cur_sel_d = sel;
                    end
                end
                SCAN: begin
                    if (cnt_q == '0) begin
                        cnt_d = CNT_RELOAD;
                        // With nothing enabled, hold position and keep timing so scanning resumes cleanly.
                        if (adv_found) begin
                            cur_sel_d = adv_sel;
                            wrap_d    = adv_wrap;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output stage: present the currently selected channel, or drive 0 when not live.
    always_comb begin
        y_d       = '0;
        y_valid_d = live;
        if (live) begin
            y_d = chan[cur_sel_q];
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cur_sel_q <= '0;
            cnt_q     <= CNT_RELOAD;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_sel_q <= cur_sel_d;
            cnt_q     <= cnt_d;
            wrap_q    <= wrap_d;
        end
    end

    // Output data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign cur_sel = cur_sel_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_scan_mux_n_to_1.sv
// tb_scan_mux_n_to_1: scoreboard bench for two selector instances (16ch/DWELL=4/1b, 10ch/DWELL=1/8b).
// Latency: expected outputs are queued at each clock edge and compared at the following falling edge.
// Backpressure: n/a.
module tb_scan_mux_n_to_1;

    typedef struct {
        int         st;   // 0 idle, 1 manual, 2 scan
        int         cur;
        int         cnt;
        logic [7:0] y;
        bit         vld;
        bit         wrap;
    } mdl_t;

    logic core_clk = 1'b0;
    logic arst_n   = 1'b0;
    always #5 core_clk = ~core_clk;

    // Instance A: 16 channels x 1 bit, dwell 4
    logic [15:0] a_d_dat = '0;
    logic [3:0]  a_sel = '0;
    logic        a_mode = 1'b0, a_start = 1'b0, a_stop = 1'b0, a_en = 1'b0;
    logic [15:0] a_mask = 16'hFFFF;
    logic        a_y, a_y_vld, a_wrap;
    logic [3:0]  a_cur;

    // Instance B: 10 channels x 8 bits, dwell 1
    logic [79:0] b_d_dat = '0;
    logic [3:0]  b_sel = '0;
    logic        b_mode = 1'b0, b_start = 1'b0, b_stop = 1'b0, b_en = 1'b0;
    logic [9:0]  b_mask = '1;
    logic [7:0]  b_y;
    logic        b_y_vld, b_wrap;
    logic [3:0]  b_cur;

    scan_mux_n_to_1 #(.WIDTH(1), .CHANNELS(16), .DWELL(4)) u_dut_a (
        .clk(core_clk), .rst_n(arst_n), .d(a_d_dat), .sel(a_sel), .mode(a_mode),
        .start(a_start), .stop(a_stop), .en(a_en),
`ifdef SCAN_MUX_CH_MASK_EN
        .mask(a_mask),
`endif
        .y(a_y), .y_valid(a_y_vld), .cur_sel(a_cur), .wrap(a_wrap)
    );

    scan_mux_n_to_1 #(.WIDTH(8), .CHANNELS(10), .DWELL(1)) u_dut_b (
        .clk(core_clk), .rst_n(arst_n), .d(b_d_dat), .sel(b_sel), .mode(b_mode),
        .start(b_start), .stop(b_stop), .en(b_en),
`ifdef SCAN_MUX_CH_MASK_EN
        .mask(b_mask),
`endif
        .y(b_y), .y_valid(b_y_vld), .cur_sel(b_cur), .wrap(b_wrap)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic mdl_t mdl_reset(input int dw);
        mdl_t m;
        m.st = 0; m.cur = 0; m.cnt = dw - 1; m.y = '0; m.vld = 0; m.wrap = 0;
        return m;
    endfunction

    // Behavioural reference: what the outputs should read after this clock edge.
    function automatic mdl_t step(input mdl_t m, input logic [127:0] dv, input int sel,
                                  input bit mode, input bit start, input bit stop, input bit en,
                                  input logic [15:0] msk, input int ch, input int dw, input int w);
        mdl_t n;
        logic [127:0] sh;
        bit live, done;
        int idx;
        n = m;
        n.wrap = 0;
        live = (m.st != 0) && !stop && en && msk[m.cur];
        sh = dv >> (m.cur * w);
        n.y = live ? (sh[7:0] & 8'((1 << w) - 1)) : 8'h00;
        n.vld = live;
        if (stop) begin
            n.st = 0;
        end else if (m.st == 0) begin
            if (start && mode) begin
                n.st = 2; n.cur = 0; n.cnt = dw - 1;
            end else if (start) begin
                n.st = 1;
                if (sel < ch) n.cur = sel;
            end
        end else if (m.st == 1) begin
            if (sel < ch) n.cur = sel;
        end else begin
            if (m.cnt == 0) begin
                n.cnt = dw - 1;
                done = 0;
                for (int j = 1; j <= ch; j++) begin
                    idx = (m.cur + j) % ch;
                    if (!done && msk[idx]) begin
                        done = 1;
                        n.cur = idx;
                        n.wrap = (m.cur + j >= ch);
                    end
                end
            end else begin
                n.cnt = m.cnt - 1;
            end
        end
        return n;
    endfunction

    mdl_t a_mdl, b_mdl;
    mdl_t a_q[$];
    mdl_t b_q[$];

    // Push expectations at each edge, from the same inputs the DUTs sample.
    always @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            a_mdl <= mdl_reset(4);
            b_mdl <= mdl_reset(1);
            a_q.delete();
            b_q.delete();
        end else begin
            a_q.push_back(step(a_mdl, 128'(a_d_dat), int'(a_sel), a_mode, a_start, a_stop, a_en,
                               a_mask, 16, 4, 1));
            b_q.push_back(step(b_mdl, 128'(b_d_dat), int'(b_sel), b_mode, b_start, b_stop, b_en,
                               16'hFFFF, 10, 1, 8));
            a_mdl <= a_q[$];
            b_mdl <= b_q[$];
        end
    end

    // Pop and compare on the falling edge; while in reset everything must read zero.
    always @(negedge core_clk) begin
        if (!arst_n) begin
            check("A.rst.y", 32'(a_y), 0);     check("A.rst.vld", 32'(a_y_vld), 0);
            check("A.rst.cur", 32'(a_cur), 0); check("A.rst.wrap", 32'(a_wrap), 0);
            check("B.rst.y", 32'(b_y), 0);     check("B.rst.vld", 32'(b_y_vld), 0);
            check("B.rst.cur", 32'(b_cur), 0); check("B.rst.wrap", 32'(b_wrap), 0);
        end else begin
            if (a_q.size() > 0) begin
                check("A.y", 32'(a_y), 32'(a_q[0].y));
                check("A.vld", 32'(a_y_vld), 32'(a_q[0].vld));
                check("A.cur", 32'(a_cur), 32'(a_q[0].cur));
                check("A.wrap", 32'(a_wrap), 32'(a_q[0].wrap));
                void'(a_q.pop_front());
            end
            if (b_q.size() > 0) begin
                check("B.y", 32'(b_y), 32'(b_q[0].y));
                check("B.vld", 32'(b_y_vld), 32'(b_q[0].vld));
                check("B.cur", 32'(b_cur), 32'(b_q[0].cur));
                check("B.wrap", 32'(b_wrap), 32'(b_q[0].wrap));
                void'(b_q.pop_front());
            end
        end
    end

    task automatic rand_d();
        a_d_dat = 16'($urandom);
        b_d_dat = 80'({$urandom, $urandom, $urandom});
    endtask

    task automatic pulse_stop();
        @(negedge core_clk);
        a_stop = 1'b1; b_stop = 1'b1;
        @(negedge core_clk);
        a_stop = 1'b0; b_stop = 1'b0;
    endtask

    int wraps, wrap_at, cur_hold;

    initial begin
        // Reset held for three cycles while inputs toggle
        for (int i = 0; i < 3; i++) begin
            @(negedge core_clk);
            rand_d();
            a_en = 1'b1; b_en = 1'b1;
        end
        #2 arst_n = 1'b1;

        // Manual: A sel=5 with d[5]=1; B sel=3
        @(negedge core_clk);
        a_d_dat = 16'($urandom) | 16'h0020;
        a_mode = 1'b0; a_sel = 4'd5; a_start = 1'b1;
        b_mode = 1'b0; b_sel = 4'd3; b_start = 1'b1;
        @(negedge core_clk);
        a_start = 1'b0; b_start = 1'b0;
        check("A.man.cur+1", 32'(a_cur), 5);
        @(negedge core_clk);
        check("A.man.y+2", 32'(a_y), 1);
        check("A.man.vld+2", 32'(a_y_vld), 1);
        // B: out-of-range select (>= 10) must leave cur_sel alone
        b_sel = 4'd13;
        @(negedge core_clk);
        @(negedge core_clk);
        check("B.man.oor_hold", 32'(b_cur), 3);
        for (int i = 0; i < 12; i++) begin
            @(negedge core_clk);
            rand_d();
            a_sel = 4'($urandom_range(0, 15));
            b_sel = 4'($urandom_range(0, 15));
            a_en  = (i != 4);
            b_en  = (i != 7);
        end
        a_en = 1'b1; b_en = 1'b1;
        pulse_stop();

        // Scan: A wraps exactly once, 64 cycles after entering SCAN; en drops mid-scan
        a_mode = 1'b1; a_start = 1'b1;
        b_mode = 1'b1; b_start = 1'b1;
        wraps = 0; wrap_at = 0;
        for (int i = 1; i <= 65; i++) begin
            @(negedge core_clk);
            a_start = 1'b0; b_start = 1'b0;
            if (a_wrap) begin
                wraps++;
                wrap_at = i;
            end
            rand_d();
            a_en = !(i >= 20 && i < 24);
            b_en = !(i >= 30 && i < 33);
        end
        check("A.scan.wrap_cnt", 32'(wraps), 1);
        check("A.scan.wrap_at", 32'(wrap_at), 65);
        a_en = 1'b1; b_en = 1'b1;

        // stop and start together during SCAN: stop wins, cur_sel holds
        repeat (5) @(negedge core_clk);
        cur_hold = int'(a_cur);
        a_stop = 1'b1; a_start = 1'b1; a_mode = 1'b0;
        @(negedge core_clk);
        a_stop = 1'b0; a_start = 1'b0;
        check("A.stop.vld+1", 32'(a_y_vld), 0);
        check("A.stop.cur+1", 32'(a_cur), 32'(cur_hold));
        repeat (3) @(negedge core_clk);
        check("A.stop.cur_held", 32'(a_cur), 32'(cur_hold));

        // Asynchronous reset while B is still scanning
        @(posedge core_clk);
        #2 arst_n = 1'b0;
        #1;
        check("B.arst.y", 32'(b_y), 0);     check("B.arst.vld", 32'(b_y_vld), 0);
        check("B.arst.cur", 32'(b_cur), 0); check("B.arst.wrap", 32'(b_wrap), 0);
        check("A.arst.cur", 32'(a_cur), 0);
        @(negedge core_clk);
        @(negedge core_clk);
        #2 arst_n = 1'b1;

`ifdef SCAN_MUX_CH_MASK_EN
        // Masked scan over channels 0,3,7; then an empty mask freezes the scan
        @(negedge core_clk);
        a_mask = 16'h0089; a_mode = 1'b1; a_start = 1'b1;
        wraps = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge core_clk);
            a_start = 1'b0;
            if (a_wrap) wraps++;
            rand_d();
        end
        check("A.mask.wrap_cnt", 32'(wraps), 2);
        a_mask = 16'h0000;
        @(negedge core_clk);
        cur_hold = int'(a_cur);
        repeat (10) @(negedge core_clk);
        check("A.mask0.cur", 32'(a_cur), 32'(cur_hold));
        check("A.mask0.vld", 32'(a_y_vld), 0);
        a_mask = 16'hFFFF;
        repeat (6) @(negedge core_clk);
        pulse_stop();
`endif

        repeat (4) @(negedge core_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
